// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined control path: opcodes, ALUOp and
// forwarding encodings, and the layout of the per-instruction control bundle.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Low byte mirrors the classic {ALUSrc..ALUOp} ordering; Jump/Link sit above it.
    localparam int B_ALU_OP     = 0;
    localparam int B_BRANCH     = 2;
    localparam int B_MEM_WRITE  = 3;
    localparam int B_MEM_READ   = 4;
    localparam int B_REG_WRITE  = 5;
    localparam int B_MEM_TO_REG = 6;
    localparam int B_ALU_SRC    = 7;
    localparam int B_JUMP       = 8;
    localparam int B_LINK       = 9;
    localparam int BUNDLE_W     = 10;

    typedef logic [BUNDLE_W-1:0] bundle_t;

    localparam bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, source-register use flags
// and the illegal-instruction flag for the ID stage.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EN_IALU = 1'b1,
    parameter bit EN_JAL  = 1'b1
) (
    input  logic       id_valid,
    input  logic [6:0] opcode,
    output bundle_t    bundle,
    output logic       use_rs1,
    output logic       use_rs2,
    output logic       illegal
);

    always_comb begin
        bundle  = BUBBLE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        illegal = id_valid;
        case (opcode)
            OP_R: begin
                bundle[B_REG_WRITE]     = 1'b1;
                bundle[B_ALU_OP +: 2]   = ALU_FUNCT;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                illegal = 1'b0;
            end
            OP_LOAD: begin
                bundle[B_ALU_SRC]       = 1'b1;
                bundle[B_MEM_TO_REG]    = 1'b1;
                bundle[B_REG_WRITE]     = 1'b1;
                bundle[B_MEM_READ]      = 1'b1;
                bundle[B_ALU_OP +: 2]   = ALU_ADD;
                use_rs1 = 1'b1;
                illegal = 1'b0;
            end
            OP_STORE: begin
                bundle[B_ALU_SRC]       = 1'b1;
                bundle[B_MEM_WRITE]     = 1'b1;
                bundle[B_ALU_OP +: 2]   = ALU_ADD;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                illegal = 1'b0;
            end
            OP_BRANCH: begin
                bundle[B_BRANCH]        = 1'b1;
                bundle[B_ALU_OP +: 2]   = ALU_SUB;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                illegal = 1'b0;
            end
            OP_IMM: begin
                if (EN_IALU) begin
                    bundle[B_ALU_SRC]     = 1'b1;
                    bundle[B_REG_WRITE]   = 1'b1;
                    bundle[B_ALU_OP +: 2] = ALU_FUNCT;
                    use_rs1 = 1'b1;
                    illegal = 1'b0;
                end
            end
            OP_JAL: begin
                if (EN_JAL) begin
                    bundle[B_JUMP]        = 1'b1;
                    bundle[B_REG_WRITE]   = 1'b1;
                    bundle[B_LINK]        = 1'b1;
                    bundle[B_ALU_OP +: 2] = ALU_ADD;
                    illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: decode in ID, carry the control bundle through
// ID/EX, EX/MEM and MEM/WB, with load-use stall, flush, forwarding and counters.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter bit EN_IALU = 1'b1,
    parameter bit EN_JAL  = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic              id_illegal,
    output logic [1:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic              wb_link,
    output logic [REG_AW-1:0] wb_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    bundle_t dec_bundle;
    logic    use_rs1;
    logic    use_rs2;
    logic    dec_illegal;

    ctrl_decode #(
        .EN_IALU (EN_IALU),
        .EN_JAL  (EN_JAL)
    ) u_decode (
        .id_valid (id_valid),
        .opcode   (id_opcode),
        .bundle   (dec_bundle),
        .use_rs1  (use_rs1),
        .use_rs2  (use_rs2),
        .illegal  (dec_illegal)
    );

    bundle_t                    idex_bundle_reg;
    logic [REG_AW-1:0]          idex_rd_reg;
    logic [1:0][REG_AW-1:0]     idex_rs_reg;
    logic                       exmem_mem_read_reg, exmem_mem_write_reg;
    logic                       exmem_reg_write_reg, exmem_mem_to_reg_reg, exmem_link_reg;
    logic [REG_AW-1:0]          exmem_rd_reg;
    logic                       memwb_reg_write_reg, memwb_mem_to_reg_reg, memwb_link_reg;
    logic [REG_AW-1:0]          memwb_rd_reg;
    logic [CNT_W-1:0]           stall_cnt_reg, flush_cnt_reg;

    logic load_use;
    logic accept;

    assign load_use = id_valid && idex_bundle_reg[B_MEM_READ] && (idex_rd_reg != '0) &&
                      (((idex_rd_reg == id_rs1) && use_rs1) || ((idex_rd_reg == id_rs2) && use_rs2));
    assign stall    = load_use && !flush;
    // Anything not accepted enters ID/EX as a full bubble, including its register fields.
    assign accept   = id_valid && !dec_illegal && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_bundle_reg      <= BUBBLE;
            idex_rd_reg          <= '0;
            idex_rs_reg          <= '0;
            exmem_mem_read_reg   <= 1'b0;
            exmem_mem_write_reg  <= 1'b0;
            exmem_reg_write_reg  <= 1'b0;
            exmem_mem_to_reg_reg <= 1'b0;
            exmem_link_reg       <= 1'b0;
            exmem_rd_reg         <= '0;
            memwb_reg_write_reg  <= 1'b0;
            memwb_mem_to_reg_reg <= 1'b0;
            memwb_link_reg       <= 1'b0;
            memwb_rd_reg         <= '0;
        end else begin
            idex_bundle_reg      <= accept ? dec_bundle : BUBBLE;
            idex_rd_reg          <= accept ? id_rd : '0;
            idex_rs_reg          <= accept ? {id_rs2, id_rs1} : '0;
            exmem_mem_read_reg   <= idex_bundle_reg[B_MEM_READ];
            exmem_mem_write_reg  <= idex_bundle_reg[B_MEM_WRITE];
            exmem_reg_write_reg  <= idex_bundle_reg[B_REG_WRITE];
            exmem_mem_to_reg_reg <= idex_bundle_reg[B_MEM_TO_REG];
            exmem_link_reg       <= idex_bundle_reg[B_LINK];
            exmem_rd_reg         <= idex_rd_reg;
            memwb_reg_write_reg  <= exmem_reg_write_reg;
            memwb_mem_to_reg_reg <= exmem_mem_to_reg_reg;
            memwb_link_reg       <= exmem_link_reg;
            memwb_rd_reg         <= exmem_rd_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (flush && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    // Operand 0 is rs1, operand 1 is rs2; the younger EX/MEM result wins.
    logic [1:0][1:0] fwd_sel;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] =
            (exmem_reg_write_reg && (exmem_rd_reg != '0) && (exmem_rd_reg == idex_rs_reg[gi])) ? FWD_EXMEM :
            (memwb_reg_write_reg && (memwb_rd_reg != '0) && (memwb_rd_reg == idex_rs_reg[gi])) ? FWD_MEMWB :
            FWD_RF;
    end

    assign fwd_a         = fwd_sel[0];
    assign fwd_b         = fwd_sel[1];
    assign id_illegal    = dec_illegal;
    assign ex_alu_op     = idex_bundle_reg[B_ALU_OP +: 2];
    assign ex_alu_src    = idex_bundle_reg[B_ALU_SRC];
    assign ex_branch     = idex_bundle_reg[B_BRANCH];
    assign ex_jump       = idex_bundle_reg[B_JUMP];
    assign mem_read      = exmem_mem_read_reg;
    assign mem_write     = exmem_mem_write_reg;
    assign wb_reg_write  = memwb_reg_write_reg;
    assign wb_mem_to_reg = memwb_mem_to_reg_reg;
    assign wb_link       = memwb_link_reg;
    assign wb_rd         = memwb_rd_reg;
    assign stall_cnt     = stall_cnt_reg;
    assign flush_cnt     = flush_cnt_reg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: decode table, hand-written hazard/forwarding/flush/config
// sequences, then random traffic against an instruction-level reference model.
module tb_ctrl_pipe;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       flush = 1'b0;

    logic        stall, id_illegal, ex_alu_src, ex_branch, ex_jump;
    logic        mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link;
    logic [1:0]  ex_alu_op, fwd_a, fwd_b;
    logic [4:0]  wb_rd;
    logic [15:0] stall_cnt, flush_cnt;

    logic        c_stall, c_id_illegal, c_ex_alu_src, c_ex_branch, c_ex_jump;
    logic        c_mem_read, c_mem_write, c_wb_reg_write, c_wb_mem_to_reg, c_wb_link;
    logic [1:0]  c_ex_alu_op, c_fwd_a, c_fwd_b;
    logic [4:0]  c_wb_rd;
    logic [1:0]  c_stall_cnt, c_flush_cnt;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall), .id_illegal(id_illegal), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_read(mem_read), .mem_write(mem_write),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_link(wb_link),
        .wb_rd(wb_rd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipe #(.REG_AW(5), .EN_IALU(1'b0), .EN_JAL(1'b0), .CNT_W(2)) dut_cfg (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(c_stall), .id_illegal(c_id_illegal), .ex_alu_op(c_ex_alu_op),
        .ex_alu_src(c_ex_alu_src), .ex_branch(c_ex_branch), .ex_jump(c_ex_jump),
        .fwd_a(c_fwd_a), .fwd_b(c_fwd_b), .mem_read(c_mem_read), .mem_write(c_mem_write),
        .wb_reg_write(c_wb_reg_write), .wb_mem_to_reg(c_wb_mem_to_reg), .wb_link(c_wb_link),
        .wb_rd(c_wb_rd), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] d, input logic f);
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = d; flush = f;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference model: instructions move through EX/MEM/WB slots; controls come from the opcode table.
    typedef struct packed {
        logic       alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
        logic [1:0] alu_op;
        logic       jump, link, legal, use1, use2;
    } ctl_t;

    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2;
    } ins_t;

    function automatic ctl_t spec_ctl(input logic [6:0] op);
        ctl_t c;
        c = '0;
        c.legal = 1'b1;
        case (op)
            OPC_R:      begin {c.alu_src, c.mem_to_reg, c.reg_write, c.mem_read, c.mem_write, c.branch, c.alu_op} = 8'b0010_0010; c.use1 = 1'b1; c.use2 = 1'b1; end
            OPC_LOAD:   begin {c.alu_src, c.mem_to_reg, c.reg_write, c.mem_read, c.mem_write, c.branch, c.alu_op} = 8'b1111_0000; c.use1 = 1'b1; end
            OPC_STORE:  begin {c.alu_src, c.mem_to_reg, c.reg_write, c.mem_read, c.mem_write, c.branch, c.alu_op} = 8'b1000_1000; c.use1 = 1'b1; c.use2 = 1'b1; end
            OPC_BRANCH: begin {c.alu_src, c.mem_to_reg, c.reg_write, c.mem_read, c.mem_write, c.branch, c.alu_op} = 8'b0000_0101; c.use1 = 1'b1; c.use2 = 1'b1; end
            OPC_IMM:    begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = 2'b10; c.use1 = 1'b1; end
            OPC_JAL:    begin c.jump = 1'b1; c.reg_write = 1'b1; c.link = 1'b1; end
            default:    c.legal = 1'b0;
        endcase
        return c;
    endfunction

    ins_t m_ex, m_mem, m_wb;
    int   m_scnt, m_fcnt;

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (m_mem.v && spec_ctl(m_mem.op).reg_write && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.v && spec_ctl(m_wb.op).reg_write && m_wb.rd != 0 && m_wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic       ill;
        logic [4:0] ex;   // {alu_src, branch, jump, alu_op}
    } vec_t;

    vec_t       tbl [9];
    int         sat_exp [6];
    logic [6:0] ops [8];
    ctl_t       c_id, c_e, c_m, c_w;
    logic       exp_stall;

    initial begin
        tbl[0] = '{1'b1, OPC_R,      1'b0, 5'b000_10};
        tbl[1] = '{1'b1, OPC_LOAD,   1'b0, 5'b100_00};
        tbl[2] = '{1'b1, OPC_STORE,  1'b0, 5'b100_00};
        tbl[3] = '{1'b1, OPC_BRANCH, 1'b0, 5'b010_01};
        tbl[4] = '{1'b1, OPC_IMM,    1'b0, 5'b100_10};
        tbl[5] = '{1'b1, OPC_JAL,    1'b0, 5'b001_00};
        tbl[6] = '{1'b1, OPC_LUI,    1'b1, 5'b000_00};
        tbl[7] = '{1'b1, OPC_BAD,    1'b1, 5'b000_00};
        tbl[8] = '{1'b0, OPC_LOAD,   1'b0, 5'b000_00};
        sat_exp = '{1, 2, 3, 3, 3, 3};
        ops = '{OPC_R, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_IMM, OPC_JAL, OPC_LUI, OPC_BAD};

        // Reset held with a valid LOAD presented
        drive(1'b1, OPC_LOAD, 5'd0, 5'd0, 5'd5, 1'b0);
        repeat (3) tick();
        check("reset_outputs", {stall, id_illegal, ex_alu_op, ex_alu_src, ex_branch, ex_jump, fwd_a, fwd_b,
                                mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link, wb_rd}, 32'd0);
        check("reset_counters", {stall_cnt, flush_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();
        id_valid = 1'b0;
        check("rel_e1_mem_read", mem_read, 1'b0);
        tick();
        check("rel_e2_mem_read", mem_read, 1'b1);
        check("rel_e2_wb_m2r", wb_mem_to_reg, 1'b0);
        tick();
        check("rel_e3_wb_m2r", wb_mem_to_reg, 1'b1);
        check("rel_e3_wb_rd", wb_rd, 5'd5);

        // Decode table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].op, 5'd0, 5'd0, 5'd7, 1'b0);
            #1;
            check($sformatf("tbl%0d_illegal", i), id_illegal, tbl[i].ill);
            tick();
            check($sformatf("tbl%0d_ex", i), {ex_alu_src, ex_branch, ex_jump, ex_alu_op}, tbl[i].ex);
        end

        // Load-use: LOAD x5 then R reading x5
        do_reset();
        drive(1'b1, OPC_LOAD, 5'd1, 5'd2, 5'd5, 1'b0);
        #1 check("lu_no_stall_load", stall, 1'b0);
        tick();
        drive(1'b1, OPC_R, 5'd5, 5'd6, 5'd7, 1'b0);
        #1 check("lu_stall", stall, 1'b1);
        tick();
        check("lu_bubble_ex", {ex_alu_src, ex_branch, ex_jump, ex_alu_op}, 5'd0);
        check("lu_stall_cnt", stall_cnt, 16'd1);
        check("lu_mem_read", mem_read, 1'b1);
        check("lu_stall_released", stall, 1'b0);
        tick();
        check("lu_r_in_ex", ex_alu_op, 2'b10);
        check("lu_fwd_a_memwb", fwd_a, 2'b01);
        check("lu_stall_cnt_hold", stall_cnt, 16'd1);
        drive(1'b1, OPC_LOAD, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive(1'b1, OPC_R, 5'd0, 5'd0, 5'd7, 1'b0);
        #1 check("lu_rd0_no_stall", stall, 1'b0);
        // Asynchronous reset in the middle of a stall
        drive(1'b1, OPC_LOAD, 5'd1, 5'd2, 5'd5, 1'b0);
        tick();
        drive(1'b1, OPC_R, 5'd5, 5'd6, 5'd7, 1'b0);
        #1 check("mid_stall", stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_stall", stall, 1'b0);
        check("async_rst_ex", {ex_alu_src, ex_alu_op, mem_read, stall_cnt}, 32'd0);
        do_reset();

        // Forwarding from EX/MEM, then from MEM/WB
        drive(1'b1, OPC_R, 5'd1, 5'd2, 5'd3, 1'b0); tick();
        drive(1'b1, OPC_R, 5'd1, 5'd2, 5'd3, 1'b0); tick();
        drive(1'b1, OPC_R, 5'd3, 5'd3, 5'd4, 1'b0); tick();
        check("fwd_exmem", {fwd_a, fwd_b}, 4'b1010);
        drive(1'b1, OPC_R, 5'd1, 5'd2, 5'd3, 1'b0); tick();
        drive(1'b1, OPC_R, 5'd1, 5'd2, 5'd8, 1'b0); tick();
        drive(1'b1, OPC_R, 5'd3, 5'd9, 5'd4, 1'b0); tick();
        check("fwd_memwb", {fwd_a, fwd_b}, 4'b0100);

        // Flush wins over a load-use hazard
        do_reset();
        drive(1'b1, OPC_LOAD, 5'd1, 5'd2, 5'd5, 1'b0); tick();
        drive(1'b1, OPC_R, 5'd5, 5'd6, 5'd7, 1'b1);
        #1 check("flush_prio_stall", stall, 1'b0);
        tick();
        check("flush_bubble_ex", {ex_alu_src, ex_branch, ex_jump, ex_alu_op}, 5'd0);
        check("flush_cnt_1", flush_cnt, 16'd1);
        check("flush_stall_cnt", stall_cnt, 16'd0);
        check("flush_load_completes", mem_read, 1'b1);

        // JAL with and without EN_JAL
        do_reset();
        drive(1'b1, OPC_JAL, 5'd0, 5'd0, 5'd1, 1'b0);
        #1 check("jal_legal", id_illegal, 1'b0);
        check("jal_cfg_illegal", c_id_illegal, 1'b1);
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        check("jal_ex_jump", {ex_jump, c_ex_jump}, 2'b10);
        tick();
        tick();
        check("jal_wb", {wb_link, wb_reg_write, wb_rd}, {2'b11, 5'd1});
        check("jal_cfg_wb", {c_wb_link, c_wb_reg_write, c_wb_rd}, 7'd0);
        drive(1'b1, OPC_IMM, 5'd0, 5'd0, 5'd2, 1'b0);
        #1 check("imm_cfg_illegal", {id_illegal, c_id_illegal}, 2'b01);

        // Saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, '0, '0, '0, 1'b1);
            tick();
            check($sformatf("sat_flush_cnt%0d", i), c_flush_cnt, sat_exp[i]);
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0);

        // Random traffic against the reference model
        do_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_scnt = 0; m_fcnt = 0;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) != 0, ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
            #1;
            c_id = spec_ctl(id_opcode);
            c_e  = m_ex.v ? spec_ctl(m_ex.op) : '0;
            exp_stall = id_valid && !flush && c_e.mem_read && m_ex.rd != 0 &&
                        ((m_ex.rd == id_rs1 && c_id.use1) || (m_ex.rd == id_rs2 && c_id.use2));
            check("rnd_stall", stall, exp_stall);
            check("rnd_illegal", id_illegal, id_valid && !c_id.legal);
            tick();
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (id_valid && c_id.legal && !exp_stall && !flush) ?
                    {1'b1, id_opcode, id_rd, id_rs1, id_rs2} : '0;
            if (exp_stall && m_scnt < 65535) m_scnt++;
            if (flush && m_fcnt < 65535) m_fcnt++;
            c_e = m_ex.v  ? spec_ctl(m_ex.op)  : '0;
            c_m = m_mem.v ? spec_ctl(m_mem.op) : '0;
            c_w = m_wb.v  ? spec_ctl(m_wb.op)  : '0;
            check("rnd_ex", {ex_alu_src, ex_branch, ex_jump, ex_alu_op}, {c_e.alu_src, c_e.branch, c_e.jump, c_e.alu_op});
            check("rnd_mem", {mem_read, mem_write}, {c_m.mem_read, c_m.mem_write});
            check("rnd_wb", {wb_reg_write, wb_mem_to_reg, wb_link}, {c_w.reg_write, c_w.mem_to_reg, c_w.link});
            check("rnd_wb_rd", wb_rd, m_wb.rd);
            check("rnd_fwd", {fwd_a, fwd_b}, {model_fwd(m_ex.rs1), model_fwd(m_ex.rs2)});
            check("rnd_cnt", {stall_cnt, flush_cnt}, {m_scnt[15:0], m_fcnt[15:0]});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised successor to the single-cycle main control decoder; sits across the ID/EX/MEM/WB boundary of the pipelined RV64 core.
- Decodes opcode in ID, then carries the control bundle through the ID/EX, EX/MEM and MEM/WB stage registers with its destination register.
- Adds load-use hazard detection (stall plus bubble), branch flush, EX operand forwarding selects, and saturating stall/flush performance counters.

Parameters:
- REG_AW, 5: register address width.
- EN_IALU, 1: decode OP-IMM (0010011) when 1; otherwise treated as illegal.
- EN_JAL, 1: decode JAL (1101111) when 1; otherwise treated as illegal.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_opcode  in  7  instruction[6:0].
- id_rs1, id_rs2, id_rd  in  REG_AW each  ID register fields.
- flush  in  1  branch or jump taken, resolved in EX.
- stall  out  1  hold PC and IF/ID this cycle.
- id_illegal  out  1  valid instruction with an unsupported opcode.
- ex_alu_op  out  2  ALUOp for EX.
- ex_alu_src  out  1  ALUSrc for EX.
- ex_branch  out  1  Branch for EX.
- ex_jump  out  1  Jump for EX.
- fwd_a, fwd_b  out  2 each  forwarding select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- mem_read, mem_write  out  1 each  MEM-stage controls.
- wb_reg_write  out  1  WB-stage write enable.
- wb_mem_to_reg  out  1  WB-stage write-back source.
- wb_link  out  1  write back PC+4.
- wb_rd  out  REG_AW  WB destination register.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Decode (combinational), bundle order {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}:
  - R 0110011: 0010_0010.
  - LOAD 0000011: 1111_0000.
  - STORE 0100011: 1000_1000.
  - BRANCH 1100011: 0000_0101.
  - OP-IMM: ALUSrc=1, RegWrite=1, ALUOp=10.
  - JAL: Jump=1, RegWrite=1, Link=1, ALUOp=00.
  - No X values. Unknown opcode or disabled type gives an all-zero bundle and id_illegal=id_valid.
- Source-use flags: rs1 is used by R/LOAD/STORE/BRANCH/OP-IMM; rs2 is used by R/STORE/BRANCH.
- Load-use stall, asserted combinationally:
  - Condition: id_valid and ID/EX.MemRead and ID/EX.rd!=0 and (rd==id_rs1 and rs1 used, or rd==id_rs2 and rs2 used).
  - Effect: bubble (all-zero bundle, rd=0) loaded into ID/EX next edge.
- Flush:
  - The next edge loads a bubble into ID/EX.
  - stall is forced to 0 when flush=1 (flush has priority).
  - EX/MEM and MEM/WB are unaffected; the branch itself completes.
- Normal edge: ID/EX ← decoded bundle gated by id_valid; EX/MEM ← ID/EX; MEM/WB ← EX/MEM. One stage per cycle, no enables downstream of ID/EX.
- Forwarding, for the EX instruction's rs1/rs2 captured in ID/EX:
  - Select 10 when EX/MEM.RegWrite and EX/MEM.rd!=0 and rd matches.
  - Else select 01 when MEM/WB.RegWrite and MEM/WB.rd!=0 and rd matches.
  - Else 00. EX/MEM wins when both match.
- Latency: a control signal appears on ex_* 1 cycle, mem_* 2 cycles and wb_* 3 cycles after the ID cycle.
- Counters:
  - stall_cnt +1 per cycle stall=1; flush_cnt +1 per cycle flush=1.
  - Both saturate at 2^CNT_W−1 with no wrap.
- Reset (asynchronous, any time including mid-stall): all stage registers, rd fields and counters go to 0, so every output is 0. The first valid instruction is decoded on the first edge after rst_n rises.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants;
  - ALUOp encodings (00 add, 01 sub/compare, 10 funct-decoded);
  - fwd select encodings;
  - bundle bit indices and bundle width;
  - the all-zero BUBBLE constant.
- Sub-module ctrl_decode: purely combinational opcode → bundle, use flags and illegal flag, parametrised by EN_IALU/EN_JAL.
- Stage registers, hazard logic, forwarding and counters stay in ctrl_pipe.

Test Plan:
- Reset state: hold rst_n=0 for 3 cycles with id_valid=1 and opcode=LOAD → all outputs 0; release → mem_read=1 exactly 2 cycles later and wb_mem_to_reg=1 one cycle after that.
- Load-use: LOAD rd=5, then R rs1=5 → stall=1 for exactly 1 cycle, ex_* all 0 in the next cycle, stall_cnt=1; same pair with rd=0 → no stall.
- Forwarding: R rd=3, R rd=3, R rs1=3 rs2=3 → third instruction in EX has fwd_a=fwd_b=10; with an unrelated instruction between the writer and reader → 01.
- Flush priority: flush=1 in the same cycle as a load-use condition → stall=0, ID/EX bubble, flush_cnt=1, stall_cnt unchanged.
- Configuration: EN_JAL=0, opcode 1101111, id_valid=1 → id_illegal=1 and bubble downstream. EN_JAL=1 → wb_link=1 and wb_reg_write=1 after 3 cycles.
- Saturation: CNT_W=2, hold flush=1 for 6 cycles → flush_cnt reads 1, 2, 3, 3, 3, 3.
